// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: single-port BRAM sequencer shared by a FIFO drain
// path (sequential writes) and random-access reads, one op per cycle.
//
// Ports:
//   bram_clk       sole clock
//   reset          synchronous active-low reset (0 = reset)
//   wr_valid       FIFO head word available (first-word-fall-through)
//   wr_data        FIFO head word
//   wr_ready       combinational pop strobe, word consumed this cycle
//   rd_req         read request, held with rd_addr until rd_ack
//   rd_addr        read address
//   rd_ack         combinational read acceptance strobe
//   rd_data        registered read result
//   rd_data_valid  one-cycle strobe, rd_data valid
//   rd_error       one-cycle strobe for an out-of-range read result
//   mem_en/mem_we  registered BRAM enable / write enable
//   mem_addr       registered BRAM address
//   mem_din        registered BRAM write data
//   mem_dout       BRAM read data
//   wr_ptr         address of the next write
//   wrapped        sticky, set on the first wrap of wr_ptr
module bram_port_arbiter #(
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 128,
    parameter int ADDR_WIDTH        = 8,
    parameter int BRAM_READ_LATENCY = 2,
    parameter int MAX_WRITE_STALL   = 4
) (
    input  logic                  bram_clk,
    input  logic                  reset,

    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_error,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,

    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic                  wrapped
);

    // Token pipeline: stage 0 lines up with the mem_en cycle, the last
    // stage with the cycle in which mem_dout carries the read data.
    localparam int PIPE_LEN = 1 + BRAM_READ_LATENCY;
    localparam int SW       = $clog2(MAX_WRITE_STALL + 1);

    localparam logic [SW-1:0]         STALL_MAX = SW'(MAX_WRITE_STALL);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } grant_t;

    grant_t                grant;
    logic                  force_wr;
    logic                  rd_in_range;
    logic                  issue_rd;
    logic [SW-1:0]         stall_cnt;
    logic [PIPE_LEN-1:0]   pipe_v;
    logic [PIPE_LEN-1:0]   pipe_e;

    // Out-of-range reads are still acked but never touch the BRAM.
    assign rd_in_range = (rd_addr <= LAST_ADDR);

    // A write that has lost MAX_WRITE_STALL times in a row wins outright.
    assign force_wr = wr_valid && (stall_cnt == STALL_MAX);

    always_comb begin
        grant = GNT_IDLE;
        if (!reset) begin
            grant = GNT_IDLE;
        end else if (force_wr) begin
            grant = GNT_WRITE;
        end else if (rd_req) begin
            grant = GNT_READ;
        end else if (wr_valid) begin
            grant = GNT_WRITE;
        end
    end

    assign wr_ready = (grant == GNT_WRITE);
    assign rd_ack   = (grant == GNT_READ);
    assign issue_rd = rd_ack && rd_in_range;

    // Starvation counter: only counts reads that beat a waiting write.
    always_ff @(posedge bram_clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!wr_valid || wr_ready) begin
            stall_cnt <= '0;
        end else if (rd_ack) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Write pointer with wrap and sticky wrap flag.
    always_ff @(posedge bram_clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            wrapped <= 1'b0;
        end else if (wr_ready) begin
            if (wr_ptr == LAST_ADDR) begin
                wr_ptr  <= '0;
                wrapped <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // BRAM command register; address/data hold when no access issues.
    always_ff @(posedge bram_clk) begin
        if (!reset) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            unique case (1'b1)
                wr_ready: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b1;
                    mem_addr <= wr_ptr;
                    mem_din  <= wr_data;
                end
                issue_rd: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_addr;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Read token pipeline; reset drops every in-flight read.
    always_ff @(posedge bram_clk) begin
        if (!reset) begin
            pipe_v <= '0;
            pipe_e <= '0;
        end else begin
            pipe_v <= {pipe_v[PIPE_LEN-2:0], issue_rd};
            pipe_e <= {pipe_e[PIPE_LEN-2:0], rd_ack && !rd_in_range};
        end
    end

    // Result register.
    always_ff @(posedge bram_clk) begin
        if (!reset) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_error      <= 1'b0;
        end else begin
            rd_data_valid <= pipe_v[PIPE_LEN-1];
            rd_error      <= pipe_e[PIPE_LEN-1];
            if (pipe_v[PIPE_LEN-1]) begin
                rd_data <= mem_dout;
            end else if (pipe_e[PIPE_LEN-1]) begin
                rd_data <= '0;
            end
        end
    end

endmodule
